// File: rtl/ace_ccu_snoop_arbiter.sv
// Merges several CCU snoop requesters onto one ACE snoop port. In-flight snoops are tracked per
// cacheline so that a second snoop to a busy line waits; CR/CD responses are routed back in order.
module ace_ccu_snoop_arbiter #(
    parameter int NoPorts         = 2,
    parameter int AddrWidth       = 64,
    parameter int DataWidth       = 64,
    parameter int DcacheLineWidth = 512,
    parameter int MaskWidth       = 4,
    parameter int MaxTrans        = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NoPorts-1:0]             slv_ac_valid_i,
    output logic [NoPorts-1:0]             slv_ac_ready_o,
    input  logic [NoPorts*AddrWidth-1:0]   slv_ac_addr_i,
    input  logic [NoPorts*4-1:0]           slv_ac_snoop_i,
    input  logic [NoPorts*3-1:0]           slv_ac_prot_i,
    input  logic [NoPorts*MaskWidth-1:0]   slv_mask_i,
    output logic [NoPorts-1:0]             slv_cr_valid_o,
    input  logic [NoPorts-1:0]             slv_cr_ready_i,
    output logic [4:0]                     slv_cr_resp_o,
    output logic [NoPorts-1:0]             slv_cd_valid_o,
    input  logic [NoPorts-1:0]             slv_cd_ready_i,
    output logic [DataWidth-1:0]           slv_cd_data_o,
    output logic                           slv_cd_last_o,
    output logic                           mst_ac_valid_o,
    input  logic                           mst_ac_ready_i,
    output logic [AddrWidth-1:0]           mst_ac_addr_o,
    output logic [3:0]                     mst_ac_snoop_o,
    output logic [2:0]                     mst_ac_prot_o,
    output logic [MaskWidth-1:0]           mst_mask_o,
    input  logic                           mst_cr_valid_i,
    output logic                           mst_cr_ready_o,
    input  logic [4:0]                     mst_cr_resp_i,
    input  logic                           mst_cd_valid_i,
    output logic                           mst_cd_ready_o,
    input  logic [DataWidth-1:0]           mst_cd_data_i,
    input  logic                           mst_cd_last_i
);
    localparam int LineOff = $clog2(DcacheLineWidth / 8);
    localparam int LineW   = AddrWidth - LineOff;
    localparam int PortW   = (NoPorts > 1) ? $clog2(NoPorts) : 1;
    localparam int SlotW   = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int CntW    = $clog2(MaxTrans + 1);

    logic [MaxTrans-1:0]  slot_valid_q, slot_valid_d;
    logic [LineW-1:0]     slot_line_q [MaxTrans];
    logic [LineW-1:0]     slot_line_d [MaxTrans];
    logic [PortW-1:0]     slot_port_q [MaxTrans];
    logic [PortW-1:0]     slot_port_d [MaxTrans];

    logic                 ac_valid_q, ac_valid_d;
    logic [AddrWidth-1:0] ac_addr_q, ac_addr_d;
    logic [3:0]           ac_snoop_q, ac_snoop_d;
    logic [2:0]           ac_prot_q, ac_prot_d;
    logic [MaskWidth-1:0] ac_mask_q, ac_mask_d;
    logic [PortW-1:0]     rr_q, rr_d;

    logic [SlotW-1:0]     cr_mem_q [MaxTrans];
    logic [SlotW-1:0]     cr_mem_d [MaxTrans];
    logic [SlotW-1:0]     cr_rd_q, cr_rd_d, cr_wr_q, cr_wr_d;
    logic [CntW-1:0]      cr_cnt_q, cr_cnt_d;
    logic [SlotW-1:0]     cd_mem_q [MaxTrans];
    logic [SlotW-1:0]     cd_mem_d [MaxTrans];
    logic [SlotW-1:0]     cd_rd_q, cd_rd_d, cd_wr_q, cd_wr_d;
    logic [CntW-1:0]      cd_cnt_q, cd_cnt_d;

    logic [LineW-1:0]     req_line [NoPorts];
    logic [NoPorts-1:0]   hazard, eligible;
    logic [2*NoPorts-1:0] elig_rot;
    logic [PortW-1:0]     winner;
    logic                 any_elig, grant, can_grant;
    logic [SlotW-1:0]     free_idx;
    logic                 free_ok;
    logic                 cr_empty, cd_empty, cr_hs, cd_hs, cr_push, cd_pop;
    logic [SlotW-1:0]     cr_head, cd_head;
    logic [PortW-1:0]     cr_port, cd_port;

    function automatic logic [SlotW-1:0] ptr_inc(input logic [SlotW-1:0] p);
        return (p == SlotW'(MaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    // A port is blocked while any tracked snoop covers the same cacheline.
    for (genvar gi = 0; gi < NoPorts; gi++) begin : g_port
        logic [MaxTrans-1:0] match;
        assign req_line[gi] = slv_ac_addr_i[gi*AddrWidth+LineOff +: LineW];
        for (genvar gj = 0; gj < MaxTrans; gj++) begin : g_slot
            assign match[gj] = slot_valid_q[gj] && (slot_line_q[gj] == req_line[gi]);
        end
        assign hazard[gi] = |match;
    end

    always_comb begin
        free_idx = '0;
        free_ok  = 1'b0;
        for (int s = MaxTrans - 1; s >= 0; s--) begin
            if (!slot_valid_q[s]) begin
                free_ok  = 1'b1;
                free_idx = SlotW'(s);
            end
        end
    end

    assign eligible  = slv_ac_valid_i & ~hazard & {NoPorts{free_ok}};
    assign elig_rot  = {eligible, eligible} >> rr_q;
    assign can_grant = !ac_valid_q || mst_ac_ready_i;

    always_comb begin
        winner   = '0;
        any_elig = 1'b0;
        for (int k = 0; k < NoPorts; k++) begin
            if (!any_elig && elig_rot[k]) begin
                any_elig = 1'b1;
                winner   = (int'(rr_q) + k >= NoPorts) ? PortW'(int'(rr_q) + k - NoPorts)
                                                       : PortW'(int'(rr_q) + k);
            end
        end
    end

    assign grant    = can_grant && any_elig;
    assign cr_empty = (cr_cnt_q == '0);
    assign cd_empty = (cd_cnt_q == '0);
    assign cr_head  = cr_mem_q[cr_rd_q];
    assign cd_head  = cd_mem_q[cd_rd_q];
    assign cr_port  = slot_port_q[cr_head];
    assign cd_port  = slot_port_q[cd_head];
    assign cr_hs    = !cr_empty && mst_cr_valid_i && slv_cr_ready_i[cr_port];
    assign cd_hs    = !cd_empty && mst_cd_valid_i && slv_cd_ready_i[cd_port];
    assign cr_push  = cr_hs && mst_cr_resp_i[0];
    assign cd_pop   = cd_hs && mst_cd_last_i;

    always_comb begin
        slv_ac_ready_o = '0;
        if (grant) slv_ac_ready_o[winner] = 1'b1;
        slv_cr_valid_o = '0;
        if (!cr_empty) slv_cr_valid_o[cr_port] = mst_cr_valid_i;
        slv_cd_valid_o = '0;
        if (!cd_empty) slv_cd_valid_o[cd_port] = mst_cd_valid_i;
        mst_cr_ready_o = !cr_empty && slv_cr_ready_i[cr_port];
        mst_cd_ready_o = !cd_empty && slv_cd_ready_i[cd_port];
        slv_cr_resp_o  = cr_empty ? '0 : mst_cr_resp_i;
        slv_cd_data_o  = cd_empty ? '0 : mst_cd_data_i;
        slv_cd_last_o  = !cd_empty && mst_cd_last_i;
    end

    assign mst_ac_valid_o = ac_valid_q;
    assign mst_ac_addr_o  = ac_addr_q;
    assign mst_ac_snoop_o = ac_snoop_q;
    assign mst_ac_prot_o  = ac_prot_q;
    assign mst_mask_o     = ac_mask_q;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_line_d  = slot_line_q;
        slot_port_d  = slot_port_q;
        ac_valid_d   = ac_valid_q;
        ac_addr_d    = ac_addr_q;
        ac_snoop_d   = ac_snoop_q;
        ac_prot_d    = ac_prot_q;
        ac_mask_d    = ac_mask_q;
        rr_d         = rr_q;
        cr_mem_d     = cr_mem_q;
        cr_rd_d      = cr_rd_q;
        cr_wr_d      = cr_wr_q;
        cd_mem_d     = cd_mem_q;
        cd_rd_d      = cd_rd_q;
        cd_wr_d      = cd_wr_q;

        if (ac_valid_q && mst_ac_ready_i) ac_valid_d = 1'b0;
        if (grant) begin
            ac_valid_d            = 1'b1;
            ac_addr_d             = slv_ac_addr_i[int'(winner)*AddrWidth +: AddrWidth];
            ac_snoop_d            = slv_ac_snoop_i[int'(winner)*4 +: 4];
            ac_prot_d             = slv_ac_prot_i[int'(winner)*3 +: 3];
            ac_mask_d             = slv_mask_i[int'(winner)*MaskWidth +: MaskWidth];
            slot_valid_d[free_idx] = 1'b1;
            slot_line_d[free_idx]  = req_line[winner];
            slot_port_d[free_idx]  = winner;
            rr_d                  = (winner == PortW'(NoPorts - 1)) ? '0 : winner + 1'b1;
            cr_mem_d[cr_wr_q]     = free_idx;
            cr_wr_d               = ptr_inc(cr_wr_q);
        end
        // A snoop that returns data moves to the CD queue; otherwise its slot retires on CR.
        if (cr_hs) begin
            cr_rd_d = ptr_inc(cr_rd_q);
            if (mst_cr_resp_i[0]) begin
                cd_mem_d[cd_wr_q] = cr_head;
                cd_wr_d           = ptr_inc(cd_wr_q);
            end else begin
                slot_valid_d[cr_head] = 1'b0;
            end
        end
        if (cd_pop) begin
            cd_rd_d               = ptr_inc(cd_rd_q);
            slot_valid_d[cd_head] = 1'b0;
        end
        cr_cnt_d = cr_cnt_q + CntW'(grant) - CntW'(cr_hs);
        cd_cnt_d = cd_cnt_q + CntW'(cr_push) - CntW'(cd_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= '0;
            ac_valid_q   <= 1'b0;
            ac_addr_q    <= '0;
            ac_snoop_q   <= '0;
            ac_prot_q    <= '0;
            ac_mask_q    <= '0;
            rr_q         <= '0;
            cr_rd_q      <= '0;
            cr_wr_q      <= '0;
            cr_cnt_q     <= '0;
            cd_rd_q      <= '0;
            cd_wr_q      <= '0;
            cd_cnt_q     <= '0;
            for (int s = 0; s < MaxTrans; s++) begin
                slot_line_q[s] <= '0;
                slot_port_q[s] <= '0;
                cr_mem_q[s]    <= '0;
                cd_mem_q[s]    <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_line_q  <= slot_line_d;
            slot_port_q  <= slot_port_d;
            ac_valid_q   <= ac_valid_d;
            ac_addr_q    <= ac_addr_d;
            ac_snoop_q   <= ac_snoop_d;
            ac_prot_q    <= ac_prot_d;
            ac_mask_q    <= ac_mask_d;
            rr_q         <= rr_d;
            cr_mem_q     <= cr_mem_d;
            cr_rd_q      <= cr_rd_d;
            cr_wr_q      <= cr_wr_d;
            cr_cnt_q     <= cr_cnt_d;
            cd_mem_q     <= cd_mem_d;
            cd_rd_q      <= cd_rd_d;
            cd_wr_q      <= cd_wr_d;
            cd_cnt_q     <= cd_cnt_d;
        end
    end
endmodule

// File: tb/tb_ace_ccu_snoop_arbiter.sv
// Directed bench for the snoop arbiter: stimulus pushes expected AC/CR/CD transactions into
// queues, negedge monitors pop and compare whenever a handshake is presented.
module tb_ace_ccu_snoop_arbiter;
    localparam int NP = 2, AW = 64, DW = 64, MW = 4, MT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NP-1:0]    slv_ac_valid_i, slv_ac_ready_o;
    logic [NP*AW-1:0] slv_ac_addr_i;
    logic [NP*4-1:0]  slv_ac_snoop_i;
    logic [NP*3-1:0]  slv_ac_prot_i;
    logic [NP*MW-1:0] slv_mask_i;
    logic [NP-1:0]    slv_cr_valid_o, slv_cr_ready_i, slv_cd_valid_o, slv_cd_ready_i;
    logic [4:0]       slv_cr_resp_o, mst_cr_resp_i;
    logic [DW-1:0]    slv_cd_data_o, mst_cd_data_i;
    logic             slv_cd_last_o, mst_cd_last_i;
    logic             mst_ac_valid_o, mst_ac_ready_i;
    logic [AW-1:0]    mst_ac_addr_o;
    logic [3:0]       mst_ac_snoop_o;
    logic [2:0]       mst_ac_prot_o;
    logic [MW-1:0]    mst_mask_o;
    logic             mst_cr_valid_i, mst_cr_ready_o, mst_cd_valid_i, mst_cd_ready_o;

    ace_ccu_snoop_arbiter #(
        .NoPorts(NP), .AddrWidth(AW), .DataWidth(DW), .DcacheLineWidth(512),
        .MaskWidth(MW), .MaxTrans(MT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_ac_valid_i(slv_ac_valid_i), .slv_ac_ready_o(slv_ac_ready_o),
        .slv_ac_addr_i(slv_ac_addr_i), .slv_ac_snoop_i(slv_ac_snoop_i),
        .slv_ac_prot_i(slv_ac_prot_i), .slv_mask_i(slv_mask_i),
        .slv_cr_valid_o(slv_cr_valid_o), .slv_cr_ready_i(slv_cr_ready_i),
        .slv_cr_resp_o(slv_cr_resp_o),
        .slv_cd_valid_o(slv_cd_valid_o), .slv_cd_ready_i(slv_cd_ready_i),
        .slv_cd_data_o(slv_cd_data_o), .slv_cd_last_o(slv_cd_last_o),
        .mst_ac_valid_o(mst_ac_valid_o), .mst_ac_ready_i(mst_ac_ready_i),
        .mst_ac_addr_o(mst_ac_addr_o), .mst_ac_snoop_o(mst_ac_snoop_o),
        .mst_ac_prot_o(mst_ac_prot_o), .mst_mask_o(mst_mask_o),
        .mst_cr_valid_i(mst_cr_valid_i), .mst_cr_ready_o(mst_cr_ready_o),
        .mst_cr_resp_i(mst_cr_resp_i),
        .mst_cd_valid_i(mst_cd_valid_i), .mst_cd_ready_o(mst_cd_ready_o),
        .mst_cd_data_i(mst_cd_data_i), .mst_cd_last_i(mst_cd_last_i)
    );

    typedef struct { logic [63:0] addr; logic [3:0] snoop; logic [2:0] prot; logic [3:0] mask; } ac_t;
    typedef struct { int port; logic [4:0] resp; } cr_t;
    typedef struct { int port; logic [63:0] data; logic last; } cd_t;

    ac_t exp_ac[$];
    cr_t exp_cr[$];
    cd_t exp_cd[$];
    ac_t e_ac;
    cr_t e_cr;
    cd_t e_cd;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: handshake never seen within 50 cycles (t=%0t)", nm, $time);
    endtask

    // Payload attributes derived from port and address so every request is distinguishable.
    function automatic ac_t mk_ac(input int p, input logic [63:0] addr);
        ac_t r;
        r.addr  = addr;
        r.snoop = addr[15:12];
        r.prot  = 3'(p + 1);
        r.mask  = 4'(1 << p);
        return r;
    endfunction

    function automatic void push_ac(input int p, input logic [63:0] addr);
        exp_ac.push_back(mk_ac(p, addr));
    endfunction

    function automatic void push_cr(input int p, input logic [4:0] resp);
        cr_t r;
        r.port = p;
        r.resp = resp;
        exp_cr.push_back(r);
    endfunction

    function automatic void push_cd(input int p, input logic [63:0] data, input logic last);
        cd_t r;
        r.port = p;
        r.data = data;
        r.last = last;
        exp_cd.push_back(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ac(input int p, input logic [63:0] addr);
        ac_t r;
        r = mk_ac(p, addr);
        slv_ac_valid_i[p]            = 1'b1;
        slv_ac_addr_i[p*AW +: AW]    = addr;
        slv_ac_snoop_i[p*4 +: 4]     = r.snoop;
        slv_ac_prot_i[p*3 +: 3]      = r.prot;
        slv_mask_i[p*MW +: MW]       = r.mask;
    endtask

    task automatic clr_ac(input int p);
        slv_ac_valid_i[p] = 1'b0;
    endtask

    task automatic wait_ac_ready(input int p);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (slv_ac_ready_o[p]) ok = 1'b1;
        end
        if (!ok) timeout($sformatf("ac_ready_p%0d", p));
    endtask

    task automatic ac_issue(input int p, input logic [63:0] addr);
        set_ac(p, addr);
        wait_ac_ready(p);
        tick();
        clr_ac(p);
    endtask

    task automatic cr_send(input logic [4:0] resp);
        bit ok;
        ok = 1'b0;
        mst_cr_valid_i = 1'b1;
        mst_cr_resp_i  = resp;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (mst_cr_ready_o) ok = 1'b1;
        end
        if (!ok) timeout("cr_ready");
        tick();
        mst_cr_valid_i = 1'b0;
        mst_cr_resp_i  = '0;
    endtask

    task automatic cd_beat(input logic [63:0] data, input logic last);
        bit ok;
        ok = 1'b0;
        mst_cd_valid_i = 1'b1;
        mst_cd_data_i  = data;
        mst_cd_last_i  = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (mst_cd_ready_o) ok = 1'b1;
        end
        if (!ok) timeout("cd_ready");
        tick();
        mst_cd_valid_i = 1'b0;
        mst_cd_last_i  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mst_ac_valid_o && mst_ac_ready_i) begin
                if (exp_ac.size() == 0) begin
                    timeout("ac_unexpected");
                end else begin
                    e_ac = exp_ac.pop_front();
                    $display("AC  addr=%h snoop=%h prot=%h mask=%h", mst_ac_addr_o, mst_ac_snoop_o,
                             mst_ac_prot_o, mst_mask_o);
                    chk("ac_addr", mst_ac_addr_o, e_ac.addr);
                    chk("ac_snoop_prot_mask", 64'({mst_ac_snoop_o, mst_ac_prot_o, mst_mask_o}),
                        64'({e_ac.snoop, e_ac.prot, e_ac.mask}));
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (slv_cr_valid_o[p] && slv_cr_ready_i[p]) begin
                    if (exp_cr.size() == 0) begin
                        timeout("cr_unexpected");
                    end else begin
                        e_cr = exp_cr.pop_front();
                        $display("CR  port=%0d resp=%b", p, slv_cr_resp_o);
                        chk("cr_port", 64'(p), 64'(e_cr.port));
                        chk("cr_resp", 64'(slv_cr_resp_o), 64'(e_cr.resp));
                    end
                end
                if (slv_cd_valid_o[p] && slv_cd_ready_i[p]) begin
                    if (exp_cd.size() == 0) begin
                        timeout("cd_unexpected");
                    end else begin
                        e_cd = exp_cd.pop_front();
                        $display("CD  port=%0d data=%h last=%b", p, slv_cd_data_o, slv_cd_last_o);
                        chk("cd_port", 64'(p), 64'(e_cd.port));
                        chk("cd_data", slv_cd_data_o, e_cd.data);
                        chk("cd_last", 64'(slv_cd_last_o), 64'(e_cd.last));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] t4_addr [4];
        slv_ac_valid_i = '0; slv_ac_addr_i = '0; slv_ac_snoop_i = '0; slv_ac_prot_i = '0;
        slv_mask_i = '0; slv_cr_ready_i = '1; slv_cd_ready_i = '1; mst_ac_ready_i = 1'b1;
        mst_cr_valid_i = 1'b0; mst_cr_resp_i = '0; mst_cd_valid_i = 1'b0; mst_cd_data_i = '0;
        mst_cd_last_i = 1'b0;
        t4_addr[0] = 64'h4000; t4_addr[1] = 64'h5000; t4_addr[2] = 64'h6000; t4_addr[3] = 64'h7000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_handshakes", 64'({mst_ac_valid_o, slv_ac_ready_o, slv_cr_valid_o, slv_cd_valid_o,
                                   mst_cr_ready_o, mst_cd_ready_o}), 64'h0);
        chk("rst_ac_payload", mst_ac_addr_o, 64'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // 1: simultaneous requests, round-robin order and CR routing
        push_ac(0, 64'h1000);
        push_ac(1, 64'h2000);
        fork
            ac_issue(0, 64'h1000);
            ac_issue(1, 64'h2000);
        join
        push_cr(0, 5'b0);
        push_cr(1, 5'b0);
        cr_send(5'b0);
        cr_send(5'b0);

        // 2: same-line hazard held until CR frees the slot; distinct line goes straight through
        push_ac(0, 64'h1000);
        ac_issue(0, 64'h1000);
        push_ac(1, 64'h1020);
        set_ac(1, 64'h1020);
        repeat (3) begin
            @(negedge clk);
            chk("t2_hazard_stall", 64'(slv_ac_ready_o[1]), 64'h0);
        end
        tick();
        push_cr(0, 5'b0);
        mst_cr_valid_i = 1'b1;
        mst_cr_resp_i  = 5'b0;
        @(negedge clk);
        chk("t2_cr_ready", 64'(mst_cr_ready_o), 64'h1);
        chk("t2_no_free_bypass", 64'(slv_ac_ready_o[1]), 64'h0);
        tick();
        mst_cr_valid_i = 1'b0;
        @(negedge clk);
        chk("t2_grant_after_free", 64'(slv_ac_ready_o[1]), 64'h1);
        tick();
        clr_ac(1);
        push_ac(1, 64'h2000);
        set_ac(1, 64'h2000);
        @(negedge clk);
        chk("t2_other_line_immediate", 64'(slv_ac_ready_o[1]), 64'h1);
        tick();
        clr_ac(1);
        push_cr(1, 5'b0);
        push_cr(1, 5'b0);
        cr_send(5'b0);
        cr_send(5'b0);

        // 3: data-carrying response, 8-beat CD burst; line stays busy until the last beat
        push_ac(0, 64'h3000);
        ac_issue(0, 64'h3000);
        push_cr(0, 5'b00001);
        cr_send(5'b00001);
        push_ac(1, 64'h3010);
        set_ac(1, 64'h3010);
        for (int b = 0; b < 8; b++) begin
            push_cd(0, 64'hC0DE_0000 + 64'(b), b == 7);
            cd_beat(64'hC0DE_0000 + 64'(b), b == 7);
            if (b == 3) begin
                @(negedge clk);
                chk("t3_line_busy_mid_burst", 64'(slv_ac_ready_o[1]), 64'h0);
                tick();
            end
        end
        @(negedge clk);
        chk("t3_slot_free_after_last", 64'(slv_ac_ready_o[1]), 64'h1);
        tick();
        clr_ac(1);
        push_cr(1, 5'b0);
        cr_send(5'b0);

        // 4: table full, fifth request waits for the first CR handshake
        for (int i = 0; i < 4; i++) begin
            push_ac(i % 2, t4_addr[i]);
            ac_issue(i % 2, t4_addr[i]);
        end
        push_ac(0, 64'h8000);
        set_ac(0, 64'h8000);
        repeat (2) begin
            @(negedge clk);
            chk("t4_full_stall", 64'(slv_ac_ready_o[0]), 64'h0);
        end
        tick();
        push_cr(0, 5'b0);
        mst_cr_valid_i = 1'b1;
        @(negedge clk);
        chk("t4_no_free_bypass", 64'(slv_ac_ready_o[0]), 64'h0);
        tick();
        mst_cr_valid_i = 1'b0;
        @(negedge clk);
        chk("t4_grant_next_cycle", 64'(slv_ac_ready_o[0]), 64'h1);
        tick();
        clr_ac(0);
        push_cr(1, 5'b0);
        push_cr(0, 5'b0);
        push_cr(1, 5'b0);
        push_cr(0, 5'b0);
        repeat (4) cr_send(5'b0);

        // 5: downstream backpressure keeps payload stable and blocks the next grant
        mst_ac_ready_i = 1'b0;
        push_ac(0, 64'h9000);
        ac_issue(0, 64'h9000);
        push_ac(1, 64'hA000);
        set_ac(1, 64'hA000);
        repeat (3) begin
            @(negedge clk);
            chk("t5_ac_valid_held", 64'(mst_ac_valid_o), 64'h1);
            chk("t5_addr_stable", mst_ac_addr_o, 64'h9000);
            chk("t5_snoop_prot_mask_stable", 64'({mst_ac_snoop_o, mst_ac_prot_o, mst_mask_o}),
                64'({4'h9, 3'h1, 4'h1}));
            chk("t5_p1_blocked", 64'(slv_ac_ready_o[1]), 64'h0);
        end
        tick();
        mst_ac_ready_i = 1'b1;
        @(negedge clk);
        chk("t5_p1_granted_on_accept", 64'(slv_ac_ready_o[1]), 64'h1);
        tick();
        clr_ac(1);
        push_cr(0, 5'b0);
        push_cr(1, 5'b0);
        cr_send(5'b0);
        cr_send(5'b0);

        // 6: reset in the middle of a CD burst with another snoop outstanding
        push_ac(1, 64'hC000);
        ac_issue(1, 64'hC000);
        push_ac(0, 64'hB000);
        ac_issue(0, 64'hB000);
        push_cr(1, 5'b00001);
        cr_send(5'b00001);
        push_cd(1, 64'hD0, 1'b0);
        cd_beat(64'hD0, 1'b0);
        push_cd(1, 64'hD1, 1'b0);
        cd_beat(64'hD1, 1'b0);
        chk("t6_ac_all_accepted", 64'(exp_ac.size()), 64'h0);
        mst_cd_valid_i = 1'b1;
        mst_cd_data_i  = 64'hD2;
        mst_cr_valid_i = 1'b1;
        rst_n          = 1'b0;
        @(negedge clk);
        chk("t6_rst_handshakes", 64'({mst_ac_valid_o, slv_ac_ready_o, slv_cr_valid_o, slv_cd_valid_o,
                                      mst_cr_ready_o, mst_cd_ready_o}), 64'h0);
        chk("t6_rst_ac_addr", mst_ac_addr_o, 64'h0);
        chk("t6_rst_cd_data", slv_cd_data_o, 64'h0);
        exp_cr.delete();
        exp_cd.delete();
        tick();
        mst_cd_valid_i = 1'b0;
        mst_cd_data_i  = '0;
        mst_cr_valid_i = 1'b0;
        rst_n          = 1'b1;
        tick();
        push_ac(0, 64'hE000);
        push_ac(1, 64'hF000);
        set_ac(0, 64'hE000);
        set_ac(1, 64'hF000);
        @(negedge clk);
        chk("t6_rr_restarts_at_port0", 64'(slv_ac_ready_o), 64'h1);
        tick();
        clr_ac(0);
        wait_ac_ready(1);
        tick();
        clr_ac(1);
        push_cr(0, 5'b0);
        push_cr(1, 5'b0);
        cr_send(5'b0);
        cr_send(5'b0);

        repeat (3) tick();
        chk("end_queues_empty", 64'(exp_ac.size() + exp_cr.size() + exp_cd.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
